// File: rtl/btn_event_ctrl.sv
// Debounced multi-button controller: 2-FF sync, tick-sampled stability filter, round-robin event FIFO.
// Events appear STABLE_TICKS ticks after a clean change; a full FIFO holds events in per-channel pend bits.
// Optional auto-repeat of held buttons is compiled in with BTN_EVT_AUTOREPEAT_EN.

module btn_event_fifo #(
    parameter int DW    = 3,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_dat_o,
    output logic          empty_o,
    output logic          full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic          push_ok, pop_ok;

    assign empty_o    = (wr_q == rd_q);
    assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign wr_d       = push_ok ? wr_q + (AW+1)'(1) : wr_q;
    assign rd_d       = pop_ok ? rd_q + (AW+1)'(1) : rd_q;
    assign head_dat_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= push_dat_i;
        end
    end
endmodule

module btn_event_ctrl #(
    parameter int NUM_BTN      = 4,
    parameter int PRESCALE     = 1000,
    parameter int STABLE_TICKS = 8,
    parameter int FIFO_DEPTH   = 4,
`ifdef BTN_EVT_AUTOREPEAT_EN
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
`endif
    localparam int IDW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_state,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [IDW-1:0]     evt_id,
    output logic               evt_press,
    output logic               overflow,
    input  logic               clr_overflow
);
    localparam int PW = $clog2(PRESCALE);
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [PW-1:0]      presc_q, presc_d;
    logic               tick;
    logic [CW-1:0]      cnt_q [NUM_BTN];
    logic [CW-1:0]      cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] state_q, state_d;
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [NUM_BTN-1:0] dir_q, dir_d;
    logic [IDW-1:0]     rr_q, rr_d;
    logic               ovf_q, ovf_d;
    logic [NUM_BTN-1:0] acc, rep, new_evt, new_dir;
    logic [IDW-1:0]     sel;
    logic               found, push, ovf_set;
    logic               fifo_empty, fifo_full;
    logic [IDW:0]       head_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    assign tick    = (presc_q == PW'(PRESCALE - 1));
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    // Any tick that sees the synchronised level equal to the debounced one restarts the run.
    always_comb begin
        state_d = state_q;
        acc     = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (sync2_q[i] == state_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CW'(STABLE_TICKS - 1)) begin
                    state_d[i] = sync2_q[i];
                    cnt_d[i]   = '0;
                    acc[i]     = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

`ifdef BTN_EVT_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW   = $clog2(RMAX + 1);

    logic [HW-1:0]      hold_q [NUM_BTN];
    logic [HW-1:0]      hold_d [NUM_BTN];
    logic [NUM_BTN-1:0] phase_q, phase_d;

    // phase_q selects the initial delay versus the steady repeat interval.
    always_comb begin
        logic [HW-1:0] hold_inc;
        logic [HW-1:0] target;
        rep      = '0;
        phase_d  = phase_q;
        hold_inc = '0;
        target   = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            hold_d[i] = hold_q[i];
            hold_inc  = hold_q[i] + HW'(1);
            target    = phase_q[i] ? HW'(REPEAT_RATE) : HW'(REPEAT_DELAY);
            if (!state_q[i] || acc[i]) begin
                hold_d[i]  = '0;
                phase_d[i] = 1'b0;
            end else if (tick) begin
                if (hold_inc == target) begin
                    rep[i]     = 1'b1;
                    hold_d[i]  = '0;
                    phase_d[i] = 1'b1;
                end else begin
                    hold_d[i] = hold_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            phase_q <= phase_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end
`else
    assign rep = '0;
`endif

    assign new_evt = acc | rep;
    assign new_dir = (acc & sync2_q) | (~acc & rep);

    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_BTN; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_BTN) begin
                idx = idx - NUM_BTN;
            end
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
    end

    assign push = found && !fifo_full;

    // A channel pushed this cycle hands its old event to the FIFO, so a new one may replace it cleanly.
    always_comb begin
        logic pushed;
        pend_d  = pend_q;
        dir_d   = dir_q;
        ovf_set = 1'b0;
        pushed  = 1'b0;
        for (int i = 0; i < NUM_BTN; i++) begin
            pushed = push && (sel == IDW'(i));
            if (pushed) begin
                pend_d[i] = 1'b0;
            end
            if (new_evt[i]) begin
                if (pend_q[i] && !pushed) begin
                    ovf_set = 1'b1;
                end
                pend_d[i] = 1'b1;
                dir_d[i]  = new_dir[i];
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (push) begin
            rr_d = (sel == IDW'(NUM_BTN - 1)) ? '0 : sel + IDW'(1);
        end
    end

    assign ovf_d = ovf_set ? 1'b1 : (clr_overflow ? 1'b0 : ovf_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            state_q <= '0;
            pend_q  <= '0;
            dir_q   <= '0;
            rr_q    <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            state_q <= state_d;
            pend_q  <= pend_d;
            dir_q   <= dir_d;
            rr_q    <= rr_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    btn_event_fifo #(
        .DW    (IDW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i ({sel, dir_q[sel]}),
        .pop_i      (evt_ready),
        .head_dat_o (head_dat),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    assign btn_state = state_q;
    assign evt_valid = !fifo_empty;
    assign evt_id    = head_dat[IDW:1];
    assign evt_press = head_dat[0];
    assign overflow  = ovf_q;
endmodule
